// File: rtl/pe_seq_ctrl_pkg.sv
// Shared definitions for the pe_seq_ctrl job sequencer: state encoding and
// default timing constants.
package pe_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_INST = 3'd1,
    ST_GAP       = 3'd2,
    ST_LOAD_DATA = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } pe_seq_state_e;

  localparam int PE_SEQ_GAP_CYCLES     = 2;
  localparam int PE_SEQ_TIMEOUT_CYCLES = 1024;
  // Gap counter width covers the legal GAP_CYCLES range 1..15.
  localparam int PE_SEQ_GAP_W          = 4;

endpackage

// File: rtl/pe_seq_fwd_reg.sv
// Registered valid/data stage used for the instruction, data and result paths.
// ZERO_IDLE=1 forces the data bus to 0 whenever valid is low.
module pe_seq_fwd_reg #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid || !ZERO_IDLE) begin
        r_data <= i_data;
      end else begin
        r_data <= '0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Job sequencer for one pe: instruction load, fixed gap, data stream, drain.
// Optional drain watchdog and sticky timeout flag with PE_SEQ_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for start; lengths captured on start
// LOAD_INST | accepting instruction words until num_inst taken
// GAP       | GAP_CYCLES idle cycles, no upstream ready
// LOAD_DATA | accepting data words until num_data taken
// DRAIN     | waiting for num_out results (or watchdog expiry)
// DONE      | one-cycle done pulse
module pe_seq_ctrl
  import pe_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 64,
  parameter int CNT_WIDTH  = 8,
  parameter int GAP_CYCLES = PE_SEQ_GAP_CYCLES
`ifdef PE_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = PE_SEQ_TIMEOUT_CYCLES
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    num_inst,
  input  logic [CNT_WIDTH-1:0]    num_data,
  input  logic [CNT_WIDTH-1:0]    num_out,
  input  logic                    inst_s_valid,
  output logic                    inst_s_ready,
  input  logic [INST_WIDTH-1:0]   inst_s_data,
  input  logic                    data_s_valid,
  output logic                    data_s_ready,
  input  logic [2*DATA_WIDTH-1:0] data_s_data,
  output logic                    pe_inst_v,
  output logic [INST_WIDTH-1:0]   pe_inst,
  output logic                    pe_din_v,
  output logic [2*DATA_WIDTH-1:0] pe_din,
  input  logic                    pe_dout_v,
  input  logic [2*DATA_WIDTH-1:0] pe_dout,
  output logic                    dout_v,
  output logic [2*DATA_WIDTH-1:0] dout,
  output logic                    busy,
`ifdef PE_SEQ_TIMEOUT_EN
  output logic                    timeout,
`endif
  output logic                    done
);

  localparam logic [PE_SEQ_GAP_W-1:0] GAP_RELOAD = PE_SEQ_GAP_W'(GAP_CYCLES - 1);

  pe_seq_state_e r_state, w_state_nxt;

  logic [CNT_WIDTH-1:0]    r_num_inst, r_num_data, r_num_out;
  logic [CNT_WIDTH-1:0]    r_inst_cnt, r_data_cnt, r_out_cnt;
  logic [CNT_WIDTH-1:0]    w_inst_cnt_inc, w_data_cnt_inc;
  logic [PE_SEQ_GAP_W-1:0] r_gap_cnt;

  logic w_inst_ready, w_data_ready;
  logic w_inst_hs, w_data_hs;
  logic w_inst_last, w_data_last;
  logic w_gap_tc, w_out_full, w_out_count, w_start_acc;
  logic w_wd_fire;

  assign w_inst_ready   = (r_state == ST_LOAD_INST);
  assign w_data_ready   = (r_state == ST_LOAD_DATA);
  assign w_inst_hs      = inst_s_valid & w_inst_ready;
  assign w_data_hs      = data_s_valid & w_data_ready;
  assign w_inst_cnt_inc = r_inst_cnt + 1'b1;
  assign w_data_cnt_inc = r_data_cnt + 1'b1;
  assign w_inst_last    = w_inst_hs && (w_inst_cnt_inc == r_num_inst);
  assign w_data_last    = w_data_hs && (w_data_cnt_inc == r_num_data);
  assign w_gap_tc       = (r_gap_cnt == '0);
  assign w_out_full     = (r_out_cnt == r_num_out);
  // Results only count once the PE can be producing output for this job.
  assign w_out_count    = pe_dout_v && !w_out_full &&
                          ((r_state == ST_LOAD_DATA) || (r_state == ST_DRAIN));

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;

  assign w_wd_fire = (r_state == ST_DRAIN) && !pe_dout_v && !w_out_full &&
                     (r_wd_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state != ST_DRAIN) || pe_dout_v) begin
        r_wd_cnt <= WD_RELOAD;
      end else if (r_wd_cnt != '0) begin
        r_wd_cnt <= r_wd_cnt - 1'b1;
      end
      if (w_start_acc) begin
        r_timeout <= 1'b0;
      end else if (w_wd_fire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_acc  = 1'b0;
    inst_s_ready = w_inst_ready;
    data_s_ready = w_data_ready;
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (num_inst == '0) ? ST_GAP : ST_LOAD_INST;
        end
      end
      ST_LOAD_INST: begin
        if (w_inst_last) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (w_gap_tc) w_state_nxt = (r_num_data == '0) ? ST_DRAIN : ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        if (w_data_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_out_full || w_wd_fire) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_num_inst <= '0;
      r_num_data <= '0;
      r_num_out  <= '0;
      r_inst_cnt <= '0;
      r_data_cnt <= '0;
      r_out_cnt  <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_inst_cnt <= '0;
        r_data_cnt <= '0;
        r_out_cnt  <= '0;
        if (start) begin
          r_num_inst <= num_inst;
          r_num_data <= num_data;
          r_num_out  <= num_out;
        end
      end else begin
        if (w_inst_hs)   r_inst_cnt <= w_inst_cnt_inc;
        if (w_data_hs)   r_data_cnt <= w_data_cnt_inc;
        if (w_out_count) r_out_cnt  <= r_out_cnt + 1'b1;
      end
      if (r_state != ST_GAP) begin
        r_gap_cnt <= GAP_RELOAD;
      end else if (!w_gap_tc) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  pe_seq_fwd_reg #(.WIDTH(INST_WIDTH), .ZERO_IDLE(1'b1)) u_fwd_inst (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_inst_hs),
    .i_data  (inst_s_data),
    .o_valid (pe_inst_v),
    .o_data  (pe_inst)
  );

  pe_seq_fwd_reg #(.WIDTH(2*DATA_WIDTH), .ZERO_IDLE(1'b1)) u_fwd_data (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_data_hs),
    .i_data  (data_s_data),
    .o_valid (pe_din_v),
    .o_data  (pe_din)
  );

  // Results are a plain one-cycle delay of the PE output, data included.
  pe_seq_fwd_reg #(.WIDTH(2*DATA_WIDTH), .ZERO_IDLE(1'b0)) u_fwd_res (
    .clk     (clk),
    .rst     (rst),
    .i_valid (pe_dout_v),
    .i_data  (pe_dout),
    .o_valid (dout_v),
    .o_data  (dout)
  );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: per-job timeline model built from the
// phase rules, randomized upstream valids and PE results, PE_SEQ_TIMEOUT_EN aware.
module tb_pe_seq_ctrl;

  localparam int DW   = 16;
  localparam int IW   = 64;
  localparam int CW   = 8;
  localparam int G    = 2;
  localparam int TO   = 16;
  localparam int MAXC = 400;

  logic            clk, rst, start;
  logic [CW-1:0]   num_inst, num_data, num_out;
  logic            inst_s_valid, inst_s_ready;
  logic [IW-1:0]   inst_s_data;
  logic            data_s_valid, data_s_ready;
  logic [2*DW-1:0] data_s_data;
  logic            pe_inst_v;
  logic [IW-1:0]   pe_inst;
  logic            pe_din_v;
  logic [2*DW-1:0] pe_din;
  logic            pe_dout_v;
  logic [2*DW-1:0] pe_dout;
  logic            dout_v;
  logic [2*DW-1:0] dout;
  logic            busy, done;
`ifdef PE_SEQ_TIMEOUT_EN
  logic            timeout;
  logic            to_prev;
`endif

  pe_seq_ctrl #(
    .DATA_WIDTH (DW),
    .INST_WIDTH (IW),
    .CNT_WIDTH  (CW),
    .GAP_CYCLES (G)
`ifdef PE_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_inst     (num_inst),
    .num_data     (num_data),
    .num_out      (num_out),
    .inst_s_valid (inst_s_valid),
    .inst_s_ready (inst_s_ready),
    .inst_s_data  (inst_s_data),
    .data_s_valid (data_s_valid),
    .data_s_ready (data_s_ready),
    .data_s_data  (data_s_data),
    .pe_inst_v    (pe_inst_v),
    .pe_inst      (pe_inst),
    .pe_din_v     (pe_din_v),
    .pe_din       (pe_din),
    .pe_dout_v    (pe_dout_v),
    .pe_dout      (pe_dout),
    .dout_v       (dout_v),
    .dout         (dout),
    .busy         (busy),
`ifdef PE_SEQ_TIMEOUT_EN
    .timeout      (timeout),
`endif
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Previous-cycle PE result inputs: the expected dout_v/dout of this cycle.
  logic            lv;
  logic [2*DW-1:0] ld;

  logic [IW-1:0]   iw [256];
  logic [2*DW-1:0] dw [256];
  bit              iv [MAXC];
  bit              dv [MAXC];
  bit              ihs[MAXC];
  bit              dhs[MAXC];
  bit              rv [MAXC];
  logic [2*DW-1:0] rd [MAXC];
  int              ii [MAXC];
  int              di [MAXC];

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {inst_s_ready, data_s_ready, pe_inst_v, pe_inst, pe_din_v, pe_din,
            dout_v, dout, busy, done};
  endfunction

  task automatic fill_words();
    for (int i = 0; i < 256; i++) begin
      iw[i] = {$urandom, $urandom};
      dw[i] = $urandom;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start        = 1'b0;
      num_inst     = CW'($urandom);
      inst_s_valid = $urandom_range(0, 1) == 1;
      inst_s_data  = {$urandom, $urandom};
      data_s_valid = $urandom_range(0, 1) == 1;
      data_s_data  = $urandom;
      pe_dout_v    = $urandom_range(0, 1) == 1;
      pe_dout      = $urandom;
      @(negedge clk);
      chk("idle_ctrl", {busy, done, inst_s_ready, data_s_ready}, 4'b0000);
      chk("idle_pe", {pe_inst_v, pe_inst, pe_din_v, pe_din}, '0);
      chk("idle_dout", {dout_v, dout}, {lv, ld});
`ifdef PE_SEQ_TIMEOUT_EN
      chk("idle_timeout", timeout, to_prev);
`endif
      lv = pe_dout_v;
      ld = pe_dout;
    end
  endtask

  // vmode: 0 random valids, 1 valids held high, 2 valids every other cycle.
  // rpct < 0 starves the drain with only two results.
  task automatic run_job(input int ni, input int nd, input int no, input int vmode,
                         input int rpct, input int abort_rel);
    int gap_start, data_start, drain_start, done_cyc, end_c, k, cnt;
    logic            ev;
    logic [IW-1:0]   ei;
    logic [2*DW-1:0] ed;
`ifdef PE_SEQ_TIMEOUT_EN
    int idle;
    bit fired;
`endif
    for (int c = 0; c < MAXC; c++) begin
      case (vmode)
        1: begin iv[c] = 1'b1; dv[c] = 1'b1; end
        2: begin iv[c] = (c % 2 == 1); dv[c] = (c % 2 == 1); end
        default: begin
          iv[c] = $urandom_range(0, 99) < 70;
          dv[c] = $urandom_range(0, 99) < 70;
        end
      endcase
      ihs[c] = 1'b0;
      dhs[c] = 1'b0;
      rd[c]  = $urandom;
    end
    k = 0;
    gap_start = 1;
    ii[0] = 0;
    for (int c = 1; c < MAXC; c++) begin
      ii[c] = k;
      if (k < ni && iv[c]) begin
        ihs[c] = 1'b1;
        k++;
        if (k == ni) gap_start = c + 1;
      end
    end
    data_start  = gap_start + G;
    drain_start = data_start;
    k = 0;
    for (int c = 0; c < MAXC; c++) begin
      di[c] = k;
      if (c >= data_start && k < nd && dv[c]) begin
        dhs[c] = 1'b1;
        k++;
        if (k == nd) drain_start = c + 1;
      end
    end
    for (int c = 0; c < MAXC; c++) begin
      if (rpct < 0) rv[c] = (c == data_start + 1) || (c == data_start + 3);
      else          rv[c] = (c >= 300) || ($urandom_range(0, 99) < rpct);
    end
    cnt = 0;
    done_cyc = -1;
`ifdef PE_SEQ_TIMEOUT_EN
    idle  = 0;
    fired = 1'b0;
`endif
    for (int c = data_start; c < MAXC; c++) begin
      if (c >= drain_start) begin
        if (cnt >= no) begin
          done_cyc = c + 1;
          break;
        end
`ifdef PE_SEQ_TIMEOUT_EN
        if (rv[c]) idle = 0;
        else begin
          idle++;
          if (idle == TO) begin
            fired    = 1'b1;
            done_cyc = c + 1;
            break;
          end
        end
`endif
      end
      if (rv[c] && cnt < no) cnt++;
    end
    if (done_cyc < 0 || done_cyc > MAXC - 2) done_cyc = MAXC - 2;
    end_c = (abort_rel >= 0) ? data_start + abort_rel : done_cyc + 1;

    for (int c = 0; c <= end_c; c++) begin
      @(posedge clk); #1;
      start        = (c == 0) || (c <= done_cyc && $urandom_range(0, 3) == 0);
      num_inst     = (c == 0) ? CW'(ni) : CW'($urandom);
      num_data     = (c == 0) ? CW'(nd) : CW'($urandom);
      num_out      = (c == 0) ? CW'(no) : CW'($urandom);
      inst_s_valid = iv[c];
      inst_s_data  = iw[ii[c]];
      data_s_valid = dv[c];
      data_s_data  = dw[di[c]];
      pe_dout_v    = rv[c];
      pe_dout      = rd[c];
      if (c == abort_rel + data_start && abort_rel >= 0) begin
        rst = 1'b0;
        #1;
        chk("abort_outs", all_outs(), '0);
`ifdef PE_SEQ_TIMEOUT_EN
        chk("abort_timeout", timeout, 1'b0);
        to_prev = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b1;
        lv  = rv[c];
        ld  = rd[c];
        return;
      end
      @(negedge clk);
      chk("busy", busy, (c >= 1 && c <= done_cyc));
      chk("done", done, (c == done_cyc));
      chk("inst_ready", inst_s_ready, (c >= 1 && c < gap_start));
      chk("data_ready", data_s_ready, (c >= data_start && c < drain_start));
      ev = (c >= 1) && ihs[(c >= 1) ? c - 1 : 0];
      ei = ev ? iw[ii[c-1]] : '0;
      chk("pe_inst", {pe_inst_v, pe_inst}, {ev, ei});
      ev = (c >= 1) && dhs[(c >= 1) ? c - 1 : 0];
      ed = ev ? dw[di[c-1]] : '0;
      chk("pe_din", {pe_din_v, pe_din}, {ev, ed});
      chk("dout", {dout_v, dout}, {lv, ld});
`ifdef PE_SEQ_TIMEOUT_EN
      chk("timeout", timeout, (c == 0) ? to_prev : (c >= done_cyc && fired));
`endif
      lv = rv[c];
      ld = rd[c];
    end
`ifdef PE_SEQ_TIMEOUT_EN
    to_prev = fired;
`endif
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    start        = 1'b0;
    num_inst     = '0;
    num_data     = '0;
    num_out      = '0;
    inst_s_valid = 1'b0;
    inst_s_data  = '0;
    data_s_valid = 1'b0;
    data_s_data  = '0;
    pe_dout_v    = 1'b0;
    pe_dout      = '0;
    lv           = 1'b0;
    ld           = '0;
`ifdef PE_SEQ_TIMEOUT_EN
    to_prev      = 1'b0;
`endif
    fill_words();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", all_outs(), '0);
`ifdef PE_SEQ_TIMEOUT_EN
    chk("reset_timeout", timeout, 1'b0);
`endif
    rst = 1'b1;
    idle_cycles(3);

    iw[0] = 64'h0_8_0000000_3_00_01_00;
    iw[1] = 64'h0_8_0000000_3_00_03_02;
    iw[2] = 64'h0_8_0000000_3_00_05_04;
    dw[0] = 32'h0004_0002;
    dw[1] = 32'h0003_0001;
    dw[2] = 32'h0008_0006;
    dw[3] = 32'h0007_0005;
    dw[4] = 32'h000c_000a;
    dw[5] = 32'h000b_0009;
    run_job(3, 6, 3, 1, 40, -1);
    idle_cycles(4);

    fill_words();
    run_job(3, 6, 3, 2, 40, -1);
    idle_cycles(2);
    run_job(0, 2, 0, 1, 40, -1);
    idle_cycles(2);
    run_job(0, 0, 0, 0, 40, -1);
    run_job(4, 8, 2, 0, 40, 2);
    idle_cycles(2);
    run_job(4, 8, 2, 0, 40, -1);
    idle_cycles(3);

`ifdef PE_SEQ_TIMEOUT_EN
    run_job(2, 3, 3, 1, -1, -1);
    idle_cycles(2);
    run_job(2, 3, 1, 1, 60, -1);
    idle_cycles(2);
`endif

    for (int j = 0; j < 20; j++) begin
      fill_words();
      run_job($urandom_range(0, 8), $urandom_range(0, 10), $urandom_range(0, 6),
              $urandom_range(0, 2), $urandom_range(10, 80), -1);
      idle_cycles($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
